// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the RV32I execute stage.
// Latches one instruction, decodes it, and steps it through EXEC, MEM and WB.
module exec_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_in,
    output logic [31:0] instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        reg_write_en,
    output logic [1:0]  imm_src,
    output logic        alu_src,
    output logic [3:0]  alu_control,
    input  logic        zero_flag,
    output logic        wb_sel,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        branch_taken,
    output logic        instr_done,
    output logic        illegal_instr,
    output logic        mem_fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        K_ALU, K_LOAD, K_STORE, K_BRANCH
    } kind_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    kind_t       kind_q;
    logic [31:0] instr_q;
    logic [1:0]  imm_src_q;
    logic        alu_src_q;
    logic [3:0]  alu_ctrl_q;
    logic        wb_sel_q;
    logic        bne_q;
    logic [7:0]  wait_cnt_q;
    logic        illegal_q;
    logic        mem_fault_q;

    logic        dec_legal;
    kind_t       dec_kind;
    logic [3:0]  dec_alu;
    logic        dec_src;
    logic [1:0]  dec_imm;
    logic        dec_bne;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        dec_legal = 1'b0;
        dec_kind  = K_ALU;
        dec_alu   = ALU_ADD;
        dec_src   = 1'b0;
        dec_imm   = 2'b00;
        dec_bne   = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_alu   = alu_of_funct3(funct3, funct7[5]);
                dec_legal = (funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                // Only the shift-right immediate reuses funct7[5]; ADDI never becomes SUB.
                dec_alu   = alu_of_funct3(funct3, funct7[5] && funct3 == 3'b101);
                dec_src   = 1'b1;
                if (funct3 == 3'b001)
                    dec_legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    dec_legal = 1'b1;
            end
            OPC_LOAD: begin
                dec_kind  = K_LOAD;
                dec_src   = 1'b1;
                dec_legal = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                dec_kind  = K_STORE;
                dec_src   = 1'b1;
                dec_imm   = 2'b01;
                dec_legal = (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                dec_kind  = K_BRANCH;
                dec_alu   = ALU_SUB;
                dec_imm   = 2'b10;
                dec_bne   = funct3[0];
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kind_q      <= K_ALU;
            instr_q     <= '0;
            imm_src_q   <= 2'b00;
            alu_src_q   <= 1'b0;
            alu_ctrl_q  <= ALU_ADD;
            wb_sel_q    <= 1'b0;
            bne_q       <= 1'b0;
            wait_cnt_q  <= '0;
            illegal_q   <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr_in;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_TRAP;
                    end else begin
                        kind_q     <= dec_kind;
                        imm_src_q  <= dec_imm;
                        alu_src_q  <= dec_src;
                        alu_ctrl_q <= dec_alu;
                        wb_sel_q   <= (dec_kind == K_LOAD);
                        bne_q      <= dec_bne;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt_q <= '0;
                    case (kind_q)
                        K_ALU:             state_q <= S_WB;
                        K_LOAD, K_STORE:   state_q <= S_MEM;
                        default:           state_q <= S_IDLE;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        wait_cnt_q <= '0;
                        state_q    <= (kind_q == K_LOAD) ? S_WB : S_IDLE;
                    end else if (wait_cnt_q == LAST_WAIT) begin
                        mem_fault_q <= 1'b1;
                        wait_cnt_q  <= '0;
                        state_q     <= S_TRAP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                S_WB:    state_q <= S_IDLE;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_TRAP;
            endcase
        end
    end

    // Strobes are decoded from the state register; done/taken also fold in
    // the same-cycle ALU flag and memory acknowledge.
    assign instr_ready   = (state_q == S_IDLE);
    assign instr         = instr_q;
    assign rs1_addr      = instr_q[19:15];
    assign rs2_addr      = instr_q[24:20];
    assign rd_addr       = instr_q[11:7];
    assign imm_src       = imm_src_q;
    assign alu_src       = alu_src_q;
    assign alu_control   = alu_ctrl_q;
    assign wb_sel        = wb_sel_q;
    assign mem_req       = (state_q == S_MEM);
    assign mem_we        = mem_req && (kind_q == K_STORE);
    assign reg_write_en  = (state_q == S_WB) && (rd_addr != 5'd0);
    assign branch_taken  = (state_q == S_EXEC) && (kind_q == K_BRANCH) && (zero_flag ^ bne_q);
    assign instr_done    = (state_q == S_WB) ||
                           ((state_q == S_EXEC) && (kind_q == K_BRANCH)) ||
                           (mem_req && mem_ack && (kind_q == K_STORE));
    assign illegal_instr = illegal_q;
    assign mem_fault     = mem_fault_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a vector table for single instructions
// plus hand-written reset, trap and memory-timeout sequences.
module tb_exec_sequencer;

    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_in;
    logic [31:0] instr;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        reg_write_en;
    logic [1:0]  imm_src;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic        zero_flag;
    logic        wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        branch_taken;
    logic        instr_done;
    logic        illegal_instr;
    logic        mem_fault;

    int n_pass   = 0;
    int n_checks = 0;

    exec_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_in(instr_in),
        .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .reg_write_en(reg_write_en), .imm_src(imm_src), .alu_src(alu_src),
        .alu_control(alu_control), .zero_flag(zero_flag), .wb_sel(wb_sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .branch_taken(branch_taken), .instr_done(instr_done),
        .illegal_instr(illegal_instr), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        zero;
        int          ack_wait;
        logic [3:0]  alu;
        logic        src;
        logic [1:0]  imm;
        logic [4:0]  rd;
        int          lat;
        logic        we;
        logic        taken;
        int          mem_cyc;
        logic        mem_we;
        logic        wb_sel;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Returns one step after the accept edge, i.e. inside the DECODE cycle.
    task automatic accept(input logic [31:0] ins);
        int w = 0;
        while (!instr_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("accept ready", {31'd0, instr_ready}, 32'd1);
        instr_in    = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   n = 0;
        int   mc = 0;
        int   lat = -1;
        logic we_seen = 1'b0;
        logic mem_we_seen = 1'b0;
        logic taken_at_done = 1'b0;
        logic wb_at_done = 1'b0;
        zero_flag = v.zero;
        mem_ack   = 1'b0;
        accept(v.ins);
        while (n < 40 && lat < 0) begin
            n++;
            if (mem_req) begin
                mc++;
                mem_ack = (mc == v.ack_wait + 1);
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
            if (n == 2) begin
                check($sformatf("v%0d alu_control", idx), {28'd0, alu_control}, {28'd0, v.alu});
                check($sformatf("v%0d alu_src", idx), {31'd0, alu_src}, {31'd0, v.src});
                check($sformatf("v%0d imm_src", idx), {30'd0, imm_src}, {30'd0, v.imm});
                check($sformatf("v%0d rd_addr", idx), {27'd0, rd_addr}, {27'd0, v.rd});
            end
            if (reg_write_en) we_seen = 1'b1;
            if (mem_req && mem_we) mem_we_seen = 1'b1;
            if (instr_done) begin
                lat           = n;
                taken_at_done = branch_taken;
                wb_at_done    = wb_sel;
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d reg_write_en", idx), {31'd0, we_seen}, {31'd0, v.we});
        check($sformatf("v%0d branch_taken", idx), {31'd0, taken_at_done}, {31'd0, v.taken});
        check($sformatf("v%0d mem cycles", idx), 32'(mc), 32'(v.mem_cyc));
        check($sformatf("v%0d mem_we", idx), {31'd0, mem_we_seen}, {31'd0, v.mem_we});
        check($sformatf("v%0d wb_sel", idx), {31'd0, wb_at_done}, {31'd0, v.wb_sel});
        check($sformatf("v%0d back to idle", idx), {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        int   mc;
        logic done_seen;
        logic we_seen;

        //          ins           zero  wait alu     src   imm    rd     lat we    taken mc we_m  wbsel
        vecs[0]  = '{32'h002081B3, 1'b0, 0, 4'b0000, 1'b0, 2'b00, 5'd3, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // ADD x3
        vecs[1]  = '{32'h402081B3, 1'b0, 0, 4'b0001, 1'b0, 2'b00, 5'd3, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // SUB x3
        vecs[2]  = '{32'h4020D233, 1'b0, 0, 4'b0111, 1'b0, 2'b00, 5'd4, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // SRA x4
        vecs[3]  = '{32'h0020B2B3, 1'b0, 0, 4'b1001, 1'b0, 2'b00, 5'd5, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // SLTU x5
        vecs[4]  = '{32'h00408013, 1'b0, 0, 4'b0000, 1'b1, 2'b00, 5'd0, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0}; // ADDI x0
        vecs[5]  = '{32'h4030D313, 1'b0, 0, 4'b0111, 1'b1, 2'b00, 5'd6, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // SRAI x6
        vecs[6]  = '{32'hFFF0C393, 1'b0, 0, 4'b0100, 1'b1, 2'b00, 5'd7, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0}; // XORI x7
        vecs[7]  = '{32'h00208063, 1'b1, 0, 4'b0001, 1'b0, 2'b10, 5'd0, 2, 1'b0, 1'b1, 0, 1'b0, 1'b0}; // BEQ z=1
        vecs[8]  = '{32'h00208063, 1'b0, 0, 4'b0001, 1'b0, 2'b10, 5'd0, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0}; // BEQ z=0
        vecs[9]  = '{32'h00209063, 1'b1, 0, 4'b0001, 1'b0, 2'b10, 5'd0, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0}; // BNE z=1
        vecs[10] = '{32'h00209063, 1'b0, 0, 4'b0001, 1'b0, 2'b10, 5'd0, 2, 1'b0, 1'b1, 0, 1'b0, 1'b0}; // BNE z=0
        vecs[11] = '{32'h0000A283, 1'b0, 3, 4'b0000, 1'b1, 2'b00, 5'd5, 7, 1'b1, 1'b0, 4, 1'b0, 1'b1}; // LW, 3 waits
        vecs[12] = '{32'h0020A223, 1'b0, 0, 4'b0000, 1'b1, 2'b01, 5'd4, 3, 1'b0, 1'b0, 1, 1'b1, 1'b0}; // SW, no wait

        instr_in  = '0;
        zero_flag = 1'b0;
        rst_n     = 1'b0;
        instr_valid = 1'b0;
        mem_ack   = 1'b0;
        #12;
        check("rst instr_ready", {31'd0, instr_ready}, 32'd1);
        check("rst instr", instr, 32'd0);
        check("rst strobes", {26'd0, reg_write_en, mem_req, mem_we, branch_taken, instr_done, 1'b0}, 32'd0);
        check("rst sticky", {30'd0, illegal_instr, mem_fault}, 32'd0);
        check("rst alu_control", {28'd0, alu_control}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Reset while the ADD sits in EXEC must abort it with no write or done.
        accept(32'h002081B3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst ready", {31'd0, instr_ready}, 32'd1);
        check("midrst done/we", {30'd0, instr_done, reg_write_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        we_seen   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (instr_done) done_seen = 1'b1;
            if (reg_write_en) we_seen = 1'b1;
        end
        check("midrst no done later", {30'd0, done_seen, we_seen}, 32'd0);
        check("midrst idle", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Unsupported opcode traps after DECODE and ignores later requests.
        accept(32'h0000007F);
        check("illegal before decode edge", {31'd0, illegal_instr}, 32'd0);
        @(posedge clk);
        #1;
        check("illegal set", {31'd0, illegal_instr}, 32'd1);
        check("trap not ready", {31'd0, instr_ready}, 32'd0);
        instr_in    = 32'h002081B3;
        instr_valid = 1'b1;
        mem_ack     = 1'b1;
        done_seen   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (instr_done || instr_ready || mem_req) done_seen = 1'b1;
        end
        check("trap stays quiet", {31'd0, done_seen}, 32'd0);
        check("illegal sticky", {31'd0, illegal_instr}, 32'd1);
        do_reset();
        check("illegal cleared by reset", {31'd0, illegal_instr}, 32'd0);

        // LB is not supported.
        accept(32'h00008283);
        @(posedge clk);
        #1;
        check("LB illegal", {31'd0, illegal_instr}, 32'd1);
        do_reset();

        // LW with no acknowledge runs out the timeout counter.
        accept(32'h0000A283);
        mem_ack   = 1'b0;
        mc        = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !mem_fault; i++) begin
            @(negedge clk);
            if (mem_req) mc++;
            if (instr_done) done_seen = 1'b1;
        end
        check("timeout mem cycles", 32'(mc), 32'(TIMEOUT));
        check("timeout mem_fault", {31'd0, mem_fault}, 32'd1);
        check("timeout req dropped", {31'd0, mem_req}, 32'd0);
        check("timeout no done/ready", {30'd0, done_seen, instr_ready}, 32'd0);
        do_reset();
        check("fault cleared by reset", {31'd0, mem_fault}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
